mips_multicycle_core: RTL

Multi-cycle successor to the single-cycle MIPS CPU top.
- Executes one instruction over 3–5 states using a shared ALU and a single unified instruction/data memory port.
- The memory port carries a req/ready handshake, so wait-state memories are supported.
- Internally contains a 32x32 register file, IR, MDR, A/B and ALUOut holding registers, and the control FSM.
- Sits between the testbench/SoC memory model and nothing else; it is the CPU top.

---
 rtl/mips_multicycle_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: shared ALU, one unified memory port with req/ready
// handshake, 32x32 register file and a classic FETCH/DECODE/... control FSM.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              retire,
    output logic              halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWR, S_WB_MEM, S_EXEC_R,
        S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0] rf_q [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, rs_val, rt_val, r_res, ea;
    logic        illegal;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign ea       = a_q + sext_imm;

    // Opcode/funct legality and the R-type ALU result
    always_comb begin
        illegal = 1'b0;
        r_res   = 32'd0;
        case (funct)
            FN_ADD:  r_res = a_q + b_q;
            FN_SUB:  r_res = a_q - b_q;
            FN_AND:  r_res = a_q & b_q;
            FN_OR:   r_res = a_q | b_q;
            FN_SLT:  r_res = {31'd0, $signed(a_q) < $signed(b_q)};
            default: r_res = 32'd0;
        endcase
        case (op)
            OP_RTYPE: illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: illegal = 1'b0;
            default:  illegal = 1'b1;
        endcase
    end

    // Next-state and datapath register updates for the control FSM
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                // Speculative branch target; pc_q already holds PC+4 here
                alu_d = pc_q + {sext_imm[29:0], 2'b00};
                if (illegal)
                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                else case (op)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_JUMP;
                endcase
            end
            S_MEMADDR: begin
                alu_d = ea;
                // Misaligned accesses never reach the memory port
                if (ea[1:0] != 2'b00)   state_d = S_HALT;
                else if (op == OP_LW)   state_d = S_MEMRD;
                else                    state_d = S_MEMWR;
            end
            S_MEMRD: if (mem_ready) begin
                mdr_d   = mem_rdata;
                state_d = S_WB_MEM;
            end
            S_MEMWR: if (mem_ready) state_d = S_FETCH;
            S_WB_MEM: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_EXEC_R: begin
                alu_d   = r_res;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_d   = ea;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // FSM state and datapath holding registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            mdr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file write port; $0 is never written
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Outputs decode straight from the state register; reset kills the request at once
    assign mem_req   = !reset && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : alu_q[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign pc_out    = pc_q;
    assign halted    = (state_q == S_HALT);
    assign retire    = !reset && ((state_q == S_MEMWR && mem_ready) || state_q == S_WB_MEM ||
                       state_q == S_WB_R || state_q == S_WB_I || state_q == S_BRANCH ||
                       state_q == S_JUMP || (state_q == S_DECODE && illegal && !HALT_ON_ILLEGAL));

endmodule
